// File: rtl/freq_div_if.sv
// Signal bundle between a frequency divider and whatever consumes its outputs.
// The consumer holds the master side and drives the enable.
interface freq_div_if #(
    parameter int unsigned CW = 1
);
    logic          en;
    logic          clk_out;
    logic          tick;
    logic [CW-1:0] count;

    modport master (
        output en,
        input  clk_out,
        input  tick,
        input  count
    );

    modport slave (
        input  en,
        output clk_out,
        output tick,
        output count
    );
endinterface

// File: rtl/freq_div.sv
// Integer clock divider: one wrapping phase counter drives a registered divided
// clock (LOW cycles low, then HIGH cycles high) and a one-cycle tick per period.
module freq_div #(
    parameter int unsigned FREQ_IN  = 25000000,
    parameter int unsigned FREQ_OUT = 1000000
) (
    input  logic      clk,
    input  logic      rst,
    freq_div_if.slave bus
);
    localparam int unsigned DIV = (FREQ_OUT == 0) ? 0 : FREQ_IN / FREQ_OUT;
    localparam int unsigned LOW = DIV - DIV / 2;
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] LOW_C = CW'(LOW);

    generate
        if (FREQ_OUT == 0 || DIV < 2) begin : g_bad_ratio
            $error("freq_div: FREQ_IN / FREQ_OUT must be at least 2");
        end
    endgenerate

    // Declaration values match reset so FPGA power-up looks like a reset.
    logic [CW-1:0] r_count   = '0;
    logic          r_clk_out = 1'b0;
    logic          r_tick    = 1'b0;

    logic          w_wrap;
    logic [CW-1:0] w_count_nxt;

    assign w_wrap      = (r_count == LAST);
    assign w_count_nxt = w_wrap ? '0 : r_count + 1'b1;

    // clk_out is computed from the next count so it always equals (count >= LOW).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (bus.en) begin
            r_count   <= w_count_nxt;
            r_clk_out <= (w_count_nxt >= LOW_C);
            r_tick    <= w_wrap;
        end else begin
            r_tick    <= 1'b0;
        end
    end

    assign bus.count   = r_count;
    assign bus.clk_out = r_clk_out;
    assign bus.tick    = r_tick;
endmodule

// File: tb/tb_freq_div.sv
// Directed bench for freq_div: four instances (DIV = 10, 5, 2, 25) checked every
// cycle against a phase model, plus hand-computed tick positions and patterns.
module tb_freq_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    freq_div_if #(.CW(4)) bus10 ();
    freq_div_if #(.CW(3)) bus5  ();
    freq_div_if #(.CW(1)) bus2  ();
    freq_div_if #(.CW(5)) bus25 ();

    freq_div #(.FREQ_IN(10), .FREQ_OUT(1)) u_div10 (
        .clk(clk), .rst(rst), .bus(bus10.slave)
    );
    freq_div #(.FREQ_IN(5), .FREQ_OUT(1)) u_div5 (
        .clk(clk), .rst(rst), .bus(bus5.slave)
    );
    freq_div #(.FREQ_IN(2), .FREQ_OUT(1)) u_div2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );
    freq_div #(.FREQ_IN(25000000), .FREQ_OUT(1000000)) u_div25 (
        .clk(clk), .rst(rst), .bus(bus25.slave)
    );

    int   divs[4] = '{10, 5, 2, 25};
    int   lows[4];
    int   ph[4];
    logic tk[4];
    logic en_v[4];

    assign bus10.en = en_v[0];
    assign bus5.en  = en_v[1];
    assign bus2.en  = en_v[2];
    assign bus25.en = en_v[3];

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] oc[4];
        logic        oo[4];
        logic        ot[4];
        oc[0] = 32'(bus10.count); oo[0] = bus10.clk_out; ot[0] = bus10.tick;
        oc[1] = 32'(bus5.count);  oo[1] = bus5.clk_out;  ot[1] = bus5.tick;
        oc[2] = 32'(bus2.count);  oo[2] = bus2.clk_out;  ot[2] = bus2.tick;
        oc[3] = 32'(bus25.count); oo[3] = bus25.clk_out; ot[3] = bus25.tick;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_count", divs[i]), oc[i], 32'(ph[i]));
            check($sformatf("d%0d_clk_out", divs[i]), 32'(oo[i]), 32'(ph[i] >= lows[i]));
            check($sformatf("d%0d_tick", divs[i]), 32'(ot[i]), 32'(tk[i]));
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step(input bit do_check);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                ph[i] = 0;
                tk[i] = 1'b0;
            end else if (en_v[i]) begin
                ph[i] = (ph[i] + 1) % divs[i];
                tk[i] = (ph[i] == 0);
            end else begin
                tk[i] = 1'b0;
            end
        end
        #1;
        if (do_check) check_all();
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [9:0]  pat5;
    int          first_tick;

    initial begin
        for (int i = 0; i < 4; i++) begin
            lows[i] = divs[i] - divs[i] / 2;
            ph[i]   = 0;
            tk[i]   = 1'b0;
            en_v[i] = 1'b0;
        end
        rst = 1'b1;
        step(0);
        step(0);
        check_all();

        // Release reset with everything enabled.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) en_v[i] = 1'b1;
        pat5 = '0;
        for (int c = 1; c <= 30; c++) begin
            step(1);
            if (bus10.tick) got_q.push_back(32'(c));
            if (c <= 10) pat5[10 - c] = bus5.clk_out;
        end
        exp_q = '{32'd10, 32'd20, 32'd30};
        check("d10_tick_count", 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            check("d10_tick_cycle", got_q.pop_front(), exp_q.pop_front());
        check("d5_clk_pattern", 32'(pat5), 32'(10'b0011000110));

        // Hold DIV=10 at count 3 for seven cycles.
        repeat (3) step(1);
        check("d10_at_3", 32'(bus10.count), 32'd3);
        en_v[0] = 1'b0;
        repeat (7) step(1);
        check("d10_hold_count", 32'(bus10.count), 32'd3);
        check("d10_hold_clk_out", 32'(bus10.clk_out), 32'd0);
        en_v[0] = 1'b1;
        step(1);
        check("d10_resume", 32'(bus10.count), 32'd4);

        // Reset pulse at count 8 with en still high.
        repeat (4) step(1);
        check("d10_at_8", 32'(bus10.count), 32'd8);
        rst = 1'b1;
        step(1);
        check("d10_rst_count", 32'(bus10.count), 32'd0);
        check("d10_rst_clk_out", 32'(bus10.clk_out), 32'd0);
        check("d10_rst_tick", 32'(bus10.tick), 32'd0);
        rst = 1'b0;
        first_tick = -1;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            if (bus10.tick && first_tick < 0) first_tick = c;
        end
        check("d10_tick_after_rst", 32'(first_tick), 32'd10);

        // Enough extra cycles to see DIV=25 complete further periods.
        repeat (40) step(1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/freq_div.md
FREQ_DIV -- requirements
Module: freq_div

Interface
REQ-001 The block SHALL have parameter FREQ_IN, default 25000000, input clock frequency in Hz.
REQ-002 The block SHALL have parameter FREQ_OUT, default 1000000, output frequency in Hz; simulation builds use FREQ_IN=10, FREQ_OUT=1.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port en  input  1  count enable; high = divider advances.
REQ-006 The block SHALL have port clk_out  output  1  registered divided clock, period DIV clk cycles.
REQ-007 The block SHALL have port tick  output  1  registered one-cycle strobe, once per output period.
REQ-008 The block SHALL have port count  output  CW  current phase counter value, CW = max(1, clog2(DIV)).

Function
REQ-009 DIV SHALL equal FREQ_IN / FREQ_OUT, integer division truncating toward zero.
REQ-010 DIV < 2 or FREQ_OUT = 0 SHALL cause an elaboration-time error; no runtime fallback.
REQ-011 LOW = DIV - floor(DIV/2) (ceil of DIV/2); HIGH = floor(DIV/2).
REQ-012 count SHALL advance on each rising clk edge with en=1: DIV-1 wraps to 0, otherwise count+1.
REQ-013 With en=0, count and clk_out SHALL hold their values.
REQ-014 clk_out SHALL be a flop output with clk_out = 1 exactly when count >= LOW, at every cycle.
REQ-015 Each period SHALL therefore be LOW cycles low followed by HIGH cycles high; for even DIV this is 50% duty.
REQ-016 For odd DIV, the low phase SHALL be one cycle longer than the high phase.
REQ-017 tick SHALL be 1 for exactly the one cycle after an enabled edge at which count wrapped DIV-1 to 0, and 0 otherwise.
REQ-018 A tick SHALL therefore coincide with count = 0 and the falling edge of clk_out.
REQ-019 With en=0, tick SHALL be 0 from the next edge onward; a deasserted en never produces or repeats a tick.
REQ-020 Latency: the first clk_out rising edge SHALL occur LOW enabled edges after reset release; the first tick after DIV enabled edges.
REQ-021 No combinational path SHALL exist from any input to clk_out, tick or count.
REQ-022 Arithmetic SHALL be unsigned; count SHALL never exceed DIV-1.

Reset
REQ-023 With rst=1 at a rising clk edge, the block SHALL set count=0, clk_out=0, tick=0, regardless of en.
REQ-024 rst SHALL take priority over en; a reset mid-period SHALL discard the partial period.
REQ-025 Counting SHALL restart from 0 on the first enabled edge after rst deasserts.
REQ-026 Initial register values SHALL equal reset values (count=0, clk_out=0, tick=0) for simulation and FPGA power-up.

Verification
REQ-027 DIV=10, rst 2 cycles then en=1 -> clk_out 0 for 5 cycles, 1 for 5, repeating; tick high on cycles 10, 20, 30 after release.
REQ-028 FREQ_IN=25000000, FREQ_OUT=1000000 -> DIV=25, clk_out low 13 / high 12 cycles, tick every 25 cycles.
REQ-029 DIV=5 -> clk_out pattern 0,0,0,1,1 repeating; count sequence 0,1,2,3,4,0.
REQ-030 DIV=2 -> clk_out toggles every cycle; tick every second cycle, aligned with clk_out=0.
REQ-031 DIV=10, en dropped for 7 cycles at count=3 -> count stays 3, clk_out stays 0, tick 0; resumes at 4 when en returns.
REQ-032 DIV=10, rst pulsed at count=8 -> next cycle count=0, clk_out=0, tick=0; next tick 10 enabled edges later.
